// File: rtl/prog_loader.sv
// prog_loader: streams configuration words LSB-first into a serial
// configuration chain and returns the chain's previous contents, captured
// from the chain tail, as readback words of the same size.
module prog_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 64
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic [WORD_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              prog_in,
   output logic              prog_en,
   input  logic              prog_out,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int N_W   = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  remaining_reg, remaining_next;
   logic [N_W-1:0]    n_reg, n_next;
   logic [N_W-1:0]    idx_reg, idx_next;
   logic [N_W-1:0]    idx_inc;
   logic [N_W-1:0]    n_load;
   logic [WORD_W-1:0] word_reg, word_next;
   logic [WORD_W-1:0] cap_reg, cap_next;
   logic [WORD_W-1:0] cap_sample;
   logic [WORD_W-1:0] rb_data_reg, rb_data_next;
   logic              prog_in_reg, prog_in_next;
   logic              prog_en_reg, prog_en_next;
   logic              rb_valid_reg, rb_valid_next;
   logic              last_bit;

   // State and datapath registers; reset abandons any pass in progress
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state_reg     <= IDLE;
         remaining_reg <= '0;
         n_reg         <= '0;
         idx_reg       <= '0;
         word_reg      <= '0;
         cap_reg       <= '0;
         rb_data_reg   <= '0;
         prog_in_reg   <= 1'b0;
         prog_en_reg   <= 1'b0;
         rb_valid_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         n_reg         <= n_next;
         idx_reg       <= idx_next;
         word_reg      <= word_next;
         cap_reg       <= cap_next;
         rb_data_reg   <= rb_data_next;
         prog_in_reg   <= prog_in_next;
         prog_en_reg   <= prog_en_next;
         rb_valid_reg  <= rb_valid_next;
      end
   end

   // Next-state logic: accept a word in LOAD, emit it bit by bit in SHIFT
   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      n_next         = n_reg;
      idx_next       = idx_reg;
      word_next      = word_reg;
      cap_next       = cap_reg;
      rb_data_next   = rb_data_reg;
      prog_in_next   = 1'b0;
      prog_en_next   = 1'b0;
      rb_valid_next  = 1'b0;
      idx_inc        = idx_reg + N_W'(1);
      cap_sample     = cap_reg | (WORD_W'(prog_out) << idx_reg);
      last_bit       = 1'b0;

      // The final word of a pass may be shorter than WORD_W
      if (32'(remaining_reg) >= WORD_W) begin
         n_load = N_W'(WORD_W);
      end else begin
         n_load = N_W'(remaining_reg);
      end

      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next     = LOAD;
               remaining_next = CNT_W'(CHAIN_LEN);
            end
         end
         LOAD: begin
            if (remaining_reg == '0) begin
               state_next = DONE;
            end else if (data_valid) begin
               state_next   = SHIFT;
               n_next       = n_load;
               idx_next     = '0;
               word_next    = data_in >> 1;
               cap_next     = '0;
               prog_in_next = data_in[0];
               prog_en_next = 1'b1;
            end
         end
         SHIFT: begin
            // Each cycle here is one enabled shift edge of the chain
            if (remaining_reg != '0) begin
               remaining_next = remaining_reg - CNT_W'(1);
            end
            last_bit = (idx_inc == n_reg) || (remaining_next == '0);
            if (last_bit) begin
               rb_data_next  = cap_sample;
               rb_valid_next = 1'b1;
               cap_next      = '0;
               state_next    = (remaining_next == '0) ? DONE : LOAD;
            end else begin
               cap_next     = cap_sample;
               idx_next     = idx_inc;
               word_next    = word_reg >> 1;
               prog_in_next = word_reg[0];
               prog_en_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign data_ready = (state_reg == LOAD);
   assign busy       = (state_reg == LOAD) || (state_reg == SHIFT);
   assign done       = (state_reg == DONE);
   assign prog_in    = prog_in_reg;
   assign prog_en    = prog_en_reg;
   assign rb_data    = rb_data_reg;
   assign rb_valid   = rb_valid_reg;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, meaning the width of each configuration word accepted.
REQ-002 The block SHALL have parameter CHAIN_LEN, default 64, meaning the total number of bits in the configuration chain (>= 1).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports: prog_clk  input  1  single clock, all state on rising edge.
REQ-004 prog_rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin a load pass; sampled in IDLE or DONE only.
REQ-006 data_in  input  WORD_W  configuration word, LSB shifted first.
REQ-007 data_valid  input  1  data_in is valid.
REQ-008 data_ready  output  1  loader accepts data_in this cycle.
REQ-009 prog_in  output  1  serial bit to head of chain.
REQ-010 prog_en  output  1  chain shift enable.
REQ-011 prog_out  input  1  serial bit from tail of chain.
REQ-012 rb_data  output  WORD_W  readback word of previous chain contents.
REQ-013 rb_valid  output  1  one-cycle strobe, rb_data valid.
REQ-014 busy  output  1  pass in progress.
REQ-015 done  output  1  pass complete, held until next start.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, SHIFT and DONE; data_ready=1 only in LOAD; busy=1 in LOAD and SHIFT; done=1 only in DONE.
REQ-017 IDLE or DONE with start=1 SHALL go to LOAD, clear the bit counter to CHAIN_LEN and clear done; start SHALL be ignored in LOAD and SHIFT.
REQ-018 In LOAD, data_valid&data_ready at edge t SHALL latch the word, set n=min(WORD_W, remaining) and enter SHIFT.
REQ-019 In SHIFT, prog_en=1 and prog_in=word bit i (i=0..n-1) SHALL be registered outputs in cycles t+1..t+n, one bit per cycle.
REQ-020 The stream SHALL be word k bit j = stream bit k*WORD_W+j, with stream bit 0 driven first.
REQ-021 After the n-th bit, the FSM SHALL return to LOAD if remaining>0, else go to DONE; prog_en SHALL be 0 in every LOAD, IDLE and DONE cycle.
REQ-022 When data_valid is low in LOAD, the FSM SHALL wait indefinitely with prog_en=0, and the chain SHALL hold.
REQ-023 prog_en SHALL be high for exactly CHAIN_LEN cycles per pass.
REQ-024 For a final partial word (CHAIN_LEN mod WORD_W != 0), only the low n bits SHALL be shifted and the upper bits SHALL be discarded.
REQ-025 On every edge with prog_en=1, prog_out SHALL be sampled into a readback shift register at position i (LSB first).
REQ-026 After n samples, rb_data SHALL present the captured bits, zero-extended above n, with rb_valid=1 for exactly one cycle (the cycle after the last shift edge).
REQ-027 rb_data SHALL hold its value until the next rb_valid.
REQ-028 data_valid asserted outside LOAD SHALL have no effect, and no word SHALL be consumed.
REQ-029 The bit counter SHALL be sized ceil(log2(CHAIN_LEN+1)) and SHALL never wrap; remaining=0 SHALL force the DONE transition.

Reset
REQ-030 While prog_rst_n=0, all outputs SHALL be 0 (data_ready, prog_in, prog_en, rb_data, rb_valid, busy, done) and the state SHALL be IDLE, immediately and independent of prog_clk.
REQ-031 Reset mid-pass SHALL abandon the pass with no further prog_en pulses; the chain is left partially loaded and a new start is required.
REQ-032 Reset deassertion SHALL take effect at the next rising edge, with the block in IDLE.

Verification (WORD_W=8, CHAIN_LEN=12 unless stated)
REQ-033 Bench SHALL cover: start, words 0xA5 then 0x3C, valid held high -> prog_in sequence 1,0,1,0,0,1,0,1 then 0,0,1,1; prog_en high for 12 cycles in bursts of 8 and 4 separated by one low cycle; done=1 after the pass.
REQ-034 Bench SHALL cover: chain preloaded 0xFFF, load 0x000 -> rb_data 0xFF then 0x0F, each with a single-cycle rb_valid.
REQ-035 Bench SHALL cover: data_valid dropped for 5 cycles before the second word -> prog_en=0 and data_ready=1 for those 5 cycles; final chain contents are unchanged versus the no-stall case.
REQ-036 Bench SHALL cover: start pulsed during SHIFT -> no effect; prog_en total is still 12.
REQ-037 Bench SHALL cover: prog_rst_n low during the 3rd shift cycle -> prog_en=0 and busy=0 immediately; after release, IDLE and done=0.
REQ-038 Bench SHALL cover: CHAIN_LEN=16, two full words -> no partial handling; exactly 16 enabled cycles; done follows the second word.
